// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants, request record and one-hot decoder for the register-file
// write arbiter.
package regfile_pkg;

    localparam int NREG = 16;
    localparam int DW   = 16;
    localparam int AW   = 4;

    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    function automatic logic [NREG-1:0] onehot_dec(input logic [AW-1:0] idx);
        logic [NREG-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back request bundle for the ALU (0) and load (1) requesters.
interface regfile_write_arbiter_if;
    import regfile_pkg::*;

    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_reg;
    logic [DW-1:0] req0_data;
    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_reg;
    logic [DW-1:0] req1_data;

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; last_g remembers who won the last
// transfer so the other requester wins the next tie.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_g;

    always_comb begin
        // NOTE: give every combinational output a default first so no path infers a latch.
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_g ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // A grant only becomes a transfer when en is high, so the pointer moves only then.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            last_g <= 1'b1;
        end else if (en && (gnt != 2'b00)) begin
            last_g <= gnt[REQ_LD];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between ALU and load write-back,
// with a one-cycle commit stage, read-select decode and forwarding hit flags.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                halt,
    regfile_write_arbiter_if.slave bus,
    input  logic [AW-1:0]       rd_reg1,
    input  logic [AW-1:0]       rd_reg2,
    output logic [NREG-1:0]     WriteReg,
    output logic [DW-1:0]       D,
    output logic [NREG-1:0]     ReadEnable1,
    output logic [NREG-1:0]     ReadEnable2,
    output logic                byp1,
    output logic                byp2,
    output logic [DW-1:0]       byp_data,
    output logic [15:0]         wr_count
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept_en;
    logic       xfer;
    wr_req_t    winner;
    logic       wv;
    wr_req_t    commit;
    logic       wr_en;

    assign req       = {bus.req1_valid, bus.req0_valid};
    assign accept_en = ~halt;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (accept_en),
        .gnt (gnt)
    );

    assign bus.req0_ready = gnt[REQ_ALU] & accept_en;
    assign bus.req1_ready = gnt[REQ_LD]  & accept_en;

    // A grant implies valid, so either ready high means a transfer this edge.
    assign xfer = bus.req0_ready | bus.req1_ready;

    always_comb begin
        winner.addr = bus.req0_reg;
        winner.data = bus.req0_data;
        if (bus.req1_ready) begin
            winner.addr = bus.req1_reg;
            winner.data = bus.req1_data;
        end
    end

    // Commit stage: address/data hold when idle so D stays stable between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wv     <= 1'b0;
            commit <= '0;
        end else begin
            wv <= xfer;
            if (xfer) begin
                commit <= winner;
            end
        end
    end

    // R0 is hardwired zero: its write completes the handshake but never reaches the file.
    assign wr_en    = wv && (commit.addr != '0);
    assign WriteReg = wr_en ? onehot_dec(commit.addr) : '0;
    assign D        = commit.data;
    assign byp_data = commit.data;

    assign ReadEnable1 = onehot_dec(rd_reg1);
    assign ReadEnable2 = onehot_dec(rd_reg2);

    assign byp1 = wv && (commit.addr == rd_reg1) && (rd_reg1 != '0);
    assign byp2 = wv && (commit.addr == rd_reg2) && (rd_reg2 != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wr_en) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    a_one_ready : assert property (@(posedge clk) disable iff (rst)
        !(bus.req0_ready && bus.req1_ready));

    a_rd_onehot : assert property (@(posedge clk)
        $onehot(ReadEnable1) && $onehot(ReadEnable2));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed vector table, reset/wrap sequences and a
// randomized run against a request-level reference model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic [3:0]  rd_reg1;
    logic [3:0]  rd_reg2;
    logic [15:0] WriteReg;
    logic [15:0] D;
    logic [15:0] ReadEnable1;
    logic [15:0] ReadEnable2;
    logic        byp1;
    logic        byp2;
    logic [15:0] byp_data;
    logic [15:0] wr_count;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .bus         (bus),
        .rd_reg1     (rd_reg1),
        .rd_reg2     (rd_reg2),
        .WriteReg    (WriteReg),
        .D           (D),
        .ReadEnable1 (ReadEnable1),
        .ReadEnable2 (ReadEnable2),
        .byp1        (byp1),
        .byp2        (byp2),
        .byp_data    (byp_data),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int h, input int v0, input int r0, input int d0,
                         input int v1, input int r1, input int d1,
                         input int s1, input int s2);
        halt           = h[0];
        bus.req0_valid = v0[0];
        bus.req0_reg   = r0[3:0];
        bus.req0_data  = d0[15:0];
        bus.req1_valid = v1[0];
        bus.req1_reg   = r1[3:0];
        bus.req1_data  = d1[15:0];
        rd_reg1        = s1[3:0];
        rd_reg2        = s2[3:0];
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One row = inputs applied for a cycle and the outputs expected during it.
    typedef struct {
        int h, v0, r0, d0, v1, r1, d1, s1, s2;
        int e_rdy0, e_rdy1, e_wr, e_d, e_b1, e_b2, e_cnt;
    } vec_t;

    vec_t tbl[19];

    // Reference model state
    int m_last;
    int m_pv[2];
    int m_pr[2];
    int m_pd[2];
    int m_cv, m_cr, m_cd;
    int m_cnt;
    int model_rf[16];
    int dut_rf[16];

    initial begin
        tbl[0]  = '{0,0,0,0,      0,0,0,      5,0, 0,0,'h0000,'h0000,0,0,0};
        tbl[1]  = '{0,1,1,'h1111, 1,2,'h2222, 0,0, 1,0,'h0000,'h0000,0,0,0};
        tbl[2]  = '{0,1,1,'h1111, 1,2,'h2222, 1,2, 0,1,'h0002,'h1111,1,0,0};
        tbl[3]  = '{0,1,1,'h1111, 1,2,'h2222, 1,2, 1,0,'h0004,'h2222,0,1,1};
        tbl[4]  = '{0,0,0,0,      0,0,0,      0,0, 0,0,'h0002,'h1111,0,0,2};
        tbl[5]  = '{0,1,3,'hBEEF, 0,0,0,      0,0, 1,0,'h0000,'h1111,0,0,3};
        tbl[6]  = '{0,0,0,0,      1,0,'h1234, 3,3, 0,1,'h0008,'hBEEF,1,1,3};
        tbl[7]  = '{0,0,0,0,      0,0,0,      0,5, 0,0,'h0000,'h1234,0,0,4};
        tbl[8]  = '{0,1,7,'hA5A5, 0,0,0,      0,0, 1,0,'h0000,'h1234,0,0,4};
        tbl[9]  = '{0,0,0,0,      0,0,0,      7,6, 0,0,'h0080,'hA5A5,1,0,4};
        tbl[10] = '{0,0,0,0,      0,0,0,      7,6, 0,0,'h0000,'hA5A5,0,0,5};
        tbl[11] = '{0,1,9,'h9999, 0,0,0,      0,0, 1,0,'h0000,'hA5A5,0,0,5};
        tbl[12] = '{1,1,4,'h4444, 1,5,'h5555, 9,0, 0,0,'h0200,'h9999,1,0,5};
        tbl[13] = '{1,1,4,'h4444, 1,5,'h5555, 9,0, 0,0,'h0000,'h9999,0,0,6};
        tbl[14] = '{1,1,4,'h4444, 1,5,'h5555, 9,0, 0,0,'h0000,'h9999,0,0,6};
        tbl[15] = '{1,1,4,'h4444, 1,5,'h5555, 9,0, 0,0,'h0000,'h9999,0,0,6};
        tbl[16] = '{0,1,4,'h4444, 1,5,'h5555, 0,0, 0,1,'h0000,'h9999,0,0,6};
        tbl[17] = '{0,0,0,0,      0,0,0,      5,5, 0,0,'h0020,'h5555,1,1,6};
        tbl[18] = '{0,0,0,0,      0,0,0,      0,0, 0,0,'h0000,'h5555,0,0,7};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 5, 0);
        #1;
        check("reset_writereg", 32'(WriteReg), 32'h0);
        check("reset_d", 32'(D), 32'h0);
        check("reset_count", 32'(wr_count), 32'h0);
        check("reset_readen1", 32'(ReadEnable1), 32'h0020);
        tick();
        tick();
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].h, tbl[i].v0, tbl[i].r0, tbl[i].d0,
                  tbl[i].v1, tbl[i].r1, tbl[i].d1, tbl[i].s1, tbl[i].s2);
            #1;
            check($sformatf("row%0d_rdy0", i), 32'(bus.req0_ready), 32'(tbl[i].e_rdy0));
            check($sformatf("row%0d_rdy1", i), 32'(bus.req1_ready), 32'(tbl[i].e_rdy1));
            check($sformatf("row%0d_writereg", i), 32'(WriteReg), 32'(tbl[i].e_wr));
            check($sformatf("row%0d_d", i), 32'(D), 32'(tbl[i].e_d));
            check($sformatf("row%0d_byp_data", i), 32'(byp_data), 32'(tbl[i].e_d));
            check($sformatf("row%0d_byp1", i), 32'(byp1), 32'(tbl[i].e_b1));
            check($sformatf("row%0d_byp2", i), 32'(byp2), 32'(tbl[i].e_b2));
            check($sformatf("row%0d_count", i), 32'(wr_count), 32'(tbl[i].e_cnt));
            check($sformatf("row%0d_readen1", i), 32'(ReadEnable1), 32'(1) << tbl[i].s1);
            check($sformatf("row%0d_readen2", i), 32'(ReadEnable2), 32'(1) << tbl[i].s2);
            tick();
        end

        // Reset asserted mid-cycle while a commit is in the stage
        drive(0, 1, 4, 'h4321, 0, 0, 0, 4, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 4, 0);
        #1;
        check("midrst_pre_writereg", 32'(WriteReg), 32'h0010);
        check("midrst_pre_byp1", 32'(byp1), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_writereg", 32'(WriteReg), 32'h0);
        check("midrst_d", 32'(D), 32'h0);
        check("midrst_count", 32'(wr_count), 32'h0);
        check("midrst_byp1", 32'(byp1), 32'h0);
        check("midrst_byp_data", 32'(byp_data), 32'h0);
        rd_reg1 = 4'd5;
        #1;
        check("midrst_readen1", 32'(ReadEnable1), 32'h0020);
        tick();
        rst = 1'b0;
        tick();
        check("postrst_writereg", 32'(WriteReg), 32'h0);
        check("postrst_count", 32'(wr_count), 32'h0);
        // Pointer was reset: the first tie goes to requester 0
        drive(0, 1, 6, 'h0606, 1, 8, 'h0808, 0, 0);
        #1;
        check("postrst_tie_rdy0", 32'(bus.req0_ready), 32'h1);
        check("postrst_tie_rdy1", 32'(bus.req1_ready), 32'h0);

        // Randomized run against the reference model
        pulse_reset();
        m_last = 1;
        m_cv = 0; m_cr = 0; m_cd = 0; m_cnt = 0;
        for (int n = 0; n < 2; n++) m_pv[n] = 0;
        for (int r = 0; r < 16; r++) begin
            model_rf[r] = 0;
            dut_rf[r]   = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int h, w, s1, s2, exp_wr;
            h = ($urandom_range(7) == 0) ? 1 : 0;
            for (int n = 0; n < 2; n++) begin
                if (m_pv[n] == 0 && $urandom_range(2) != 0) begin
                    m_pv[n] = 1;
                    m_pr[n] = (cyc < 200) ? $urandom_range(15) : $urandom_range(3);
                    m_pd[n] = $urandom_range(65535);
                end
            end
            s1 = $urandom_range(15);
            s2 = (cyc % 3 == 0) ? m_cr : $urandom_range(15);
            drive(h, m_pv[0], m_pr[0], m_pd[0], m_pv[1], m_pr[1], m_pd[1], s1, s2);

            w = -1;
            if (h == 0) begin
                if (m_pv[0] != 0 && m_pv[1] != 0) w = 1 - m_last;
                else if (m_pv[0] != 0)            w = 0;
                else if (m_pv[1] != 0)            w = 1;
            end
            exp_wr = (m_cv != 0 && m_cr != 0) ? (1 << m_cr) : 0;
            #1;
            check("rand_rdy0", 32'(bus.req0_ready), 32'(w == 0));
            check("rand_rdy1", 32'(bus.req1_ready), 32'(w == 1));
            check("rand_writereg", 32'(WriteReg), 32'(exp_wr));
            check("rand_d", 32'(D), 32'(m_cd));
            check("rand_byp1", 32'(byp1), 32'(m_cv != 0 && m_cr == s1 && s1 != 0));
            check("rand_byp2", 32'(byp2), 32'(m_cv != 0 && m_cr == s2 && s2 != 0));
            check("rand_count", 32'(wr_count), 32'(m_cnt));
            for (int r = 0; r < 16; r++) begin
                if (WriteReg[r]) dut_rf[r] = int'(D);
            end
            tick();

            if (exp_wr != 0) begin
                m_cnt = (m_cnt + 1) % 65536;
                model_rf[m_cr] = m_cd;
            end
            if (w >= 0) begin
                m_cv = 1;
                m_cr = m_pr[w];
                m_cd = m_pd[w];
                m_pv[w] = 0;
                m_last = w;
            end else begin
                m_cv = 0;
            end
        end
        for (int r = 0; r < 16; r++) begin
            check($sformatf("rf_r%0d", r), 32'(dut_rf[r]), 32'(model_rf[r]));
        end

        // Counter wrap: 65536 back-to-back accepts to a non-zero register
        pulse_reset();
        drive(0, 1, 1, 'h0001, 0, 0, 0, 0, 0);
        repeat (65536) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("wrap_count_max", 32'(wr_count), 32'hFFFF);
        check("wrap_writereg", 32'(WriteReg), 32'h0002);
        tick();
        check("wrap_count_zero", 32'(wr_count), 32'h0000);
        check("wrap_idle_writereg", 32'(WriteReg), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16 x 16-bit register file between two write-back requesters: ALU result and memory load.
- Arbitrates with round-robin priority and a valid/ready handshake, then registers the winner into a one-cycle commit stage.
- The commit stage drives the register file's one-hot write enables and write data.
- Also decodes the two read-port selects into one-hot read enables, and flags read-after-write hits against the in-flight commit for forwarding logic.

Parameters:
- NREG, 16, number of architectural registers (one-hot enable width).
- DW, 16, data width.
- AW, 4, register index width; must satisfy 2**AW == NREG.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- halt  in  1  when 1, no new writes are accepted; the commit stage still drains.
- req0_valid  in  1  ALU write request.
- req0_ready  out  1  ALU write accepted this cycle.
- req0_reg  in  AW  ALU destination register.
- req0_data  in  DW  ALU write data.
- req1_valid  in  1  load write request.
- req1_ready  out  1  load write accepted this cycle.
- req1_reg  in  AW  load destination register.
- req1_data  in  DW  load write data.
- rd_reg1  in  AW  read port 1 register select.
- rd_reg2  in  AW  read port 2 register select.
- WriteReg  out  NREG  one-hot register write enables to the register file.
- D  out  DW  write data to the register file.
- ReadEnable1  out  NREG  one-hot read enable, port 1.
- ReadEnable2  out  NREG  one-hot read enable, port 2.
- byp1  out  1  rd_reg1 matches the in-flight commit.
- byp2  out  1  rd_reg2 matches the in-flight commit.
- byp_data  out  DW  in-flight commit data, for forwarding.
- wr_count  out  16  count of committed writes, excluding R0 writes.

Behaviour:
- Handshake
  - A transfer on requester n occurs when reqn_valid and reqn_ready are both 1 at a rising edge.
  - reqn_ready is combinational: reqn_ready = grant_n & ~halt.
  - A requester must hold reg/data stable while valid is 1 and ready is 0.
- Arbitration
  - Only one requester valid: it is granted.
  - Both valid: the requester that was not granted last wins.
  - Pointer last_g updates only on an actual transfer.
  - Reset sets last_g = 1, so requester 0 wins the first tie.
  - At most one ready is 1 in any cycle.
- Commit stage (registered)
  - On a transfer: wv <= 1, wreg <= reqn_reg, wdata <= reqn_data.
  - Otherwise: wv <= 0, and wreg/wdata hold their values.
  - Latency is one cycle from accept to WriteReg.
  - Throughput is one write per cycle, so back-to-back accepts are allowed.
- Write outputs
  - WriteReg = (wv && wreg != 0) ? (1 << wreg) : 0. R0 is hardwired zero; an R0 write completes its handshake but is silently dropped.
  - D = wdata at all times.
- Read enables
  - Purely combinational: ReadEnable1 = 1 << rd_reg1, ReadEnable2 = 1 << rd_reg2. Always exactly one bit set.
- Bypass
  - bypk = wv && wreg == rd_regk && rd_regk != 0.
  - byp_data = wdata.
  - The register file writes on the same edge it is read after, so forwarding logic muxes byp_data in when bypk is 1.
- wr_count
  - Increments by 1 on every cycle where WriteReg != 0.
  - Wraps from 0xFFFF to 0x0000.
- halt
  - Both readies are 0 and last_g is frozen.
  - A commit already in the stage still fires on the next cycle.
- Reset (async, any time, including mid-commit)
  - wv = 0, wreg = 0, wdata = 0, last_g = 1, wr_count = 0.
  - Hence WriteReg = 0, D = 0, byp1 = byp2 = 0, byp_data = 0.
  - ReadEnable1/2 follow their inputs even during reset.
  - A write pending at reset assertion is lost.
- Same register from both requesters on consecutive cycles: committed in grant order; the later write wins.

Decomposition:
- Shared package regfile_pkg:
  - NREG, DW, AW constants.
  - Requester index constants REQ_ALU = 0, REQ_LD = 1.
  - Function onehot_dec(AW index) returning an NREG-bit vector, used for WriteReg and ReadEnable1/2.
- One sub-module, rr_arb2: the two-requester round-robin arbiter holding last_g.
  - Inputs: clk, rst, req[1:0], en.
  - Output: gnt[1:0].
- Everything else lives in the top module.

Test Plan:
1. Reset state:
   - Assert rst mid-cycle with wv = 1 -> WriteReg = 0, D = 0, wr_count = 0, byp1 = 0 immediately.
   - rd_reg1 = 5 -> ReadEnable1 = 0x0020.
2. Single write:
   - req0 {reg 3, data 0xBEEF} for one cycle -> req0_ready = 1 that cycle.
   - Next cycle: WriteReg = 0x0008, D = 0xBEEF, wr_count = 1.
3. Tie round-robin:
   - Both valid for 3 cycles, req0 {reg 1, 0x1111}, req1 {reg 2, 0x2222}, requesters holding after accept.
   - Grants go req0, req1, req0.
   - WriteReg sequence: 0x0002, 0x0004, 0x0002.
4. R0 drop:
   - req1 {reg 0, 0x1234} -> req1_ready = 1.
   - Next cycle: WriteReg = 0, wr_count unchanged.
   - rd_reg1 = 0 -> byp1 = 0.
5. Bypass:
   - Accept req0 {reg 7, 0xA5A5}; next cycle rd_reg1 = 7, rd_reg2 = 6 -> byp1 = 1, byp2 = 0, byp_data = 0xA5A5.
   - One cycle later: byp1 = 0.
6. Halt and wrap:
   - halt = 1 with both valid for 4 cycles -> both readies 0; an earlier accept still commits.
   - Preload via 65535 commits, then one more commit -> wr_count 0xFFFF -> 0x0000.
